// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared RISC-V constants and fetch FSM encoding.
package instruction_fetch_pkg;
   localparam int XLEN = 32;
   localparam int INST_STRIDE = 4;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_inst_fifo.sv
// inst_fifo: power-of-two circular buffer of {pc, instruction} entries with flush.
module inst_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] head, tail;
   assign dout = mem[head];
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop) head <= head + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   // Storage is deliberately left out of reset; validity is tracked by count.
   always_ff @(posedge clk)
      if (push && !flush) mem[tail] <= din;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer feeding a small instruction buffer; halts on ECALL/EBREAK.
module instruction_fetch #(
   parameter int              XLEN     = instruction_fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_out,
   output logic [XLEN-1:0] inst_pc,
   output logic            halted
);
   import instruction_fetch_pkg::*;
   fetch_state_t state;
   logic [XLEN-1:0] fetch_pc;
   logic push, pop, full, empty, is_sys;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [XLEN+31:0] head_entry;
   assign imem_addr = fetch_pc;
   assign inst_valid = fifo_count != '0;
   assign pop = !empty && inst_ready && !redirect_valid;
   assign push = state == RUN && !redirect_valid && (!full || pop);
   assign is_sys = imem_data == ECALL || imem_data == EBREAK;
   assign {inst_pc, inst_out} = head_entry;
   inst_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + 32)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .flush(redirect_valid),
      .din({fetch_pc, imem_data}),
      .dout(head_entry),
      .full(full),
      .empty(empty),
      .count(fifo_count)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= BOOT;
         fetch_pc <= RESET_PC;
         halted <= 1'b0;
      end else if (redirect_valid) begin
         state <= RUN;
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         halted <= 1'b0;
      end else if (state == BOOT) begin
         state <= RUN;
      end else if (push) begin
         fetch_pc <= fetch_pc + XLEN'(INST_STRIDE);
         // The system instruction itself is buffered; fetching stops after it.
         if (is_sys) begin
            state <= HALT;
            halted <= 1'b1;
         end
      end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven directed checks plus reset/boot/wrap sequences.
module tb_instruction_fetch;
   logic clk = 1'b0, reset = 1'b1;
   logic [31:0] imem_addr, imem_data, redirect_pc = '0, inst_out, inst_pc;
   logic redirect_valid = 1'b0, inst_valid, inst_ready = 1'b0, halted;
   logic ecall_en = 1'b0, ebreak_en = 1'b0;
   logic [31:0] w_addr, w_data, w_out, w_pc;
   logic w_valid, w_halted;
   int total = 0, bad = 0;

   typedef struct {
      logic [31:0] rdy, rv, rpc, ec, v, pc, out, addr, h;
   } vec_t;
   vec_t vec [$];

   always #5 clk = ~clk;

   assign imem_data = (ecall_en && imem_addr == 32'hC) ? 32'h0000_0073 :
                      (ebreak_en && imem_addr == 32'h24) ? 32'h0010_0073 : imem_addr >> 2;
   assign w_data = w_addr >> 2;

   instruction_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .halted(halted)
   );

   instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
      .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_data(w_data),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .inst_valid(w_valid),
      .inst_ready(inst_ready), .inst_out(w_out), .inst_pc(w_pc), .halted(w_halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] v, input logic [31:0] pc,
                           input logic [31:0] out, input logic [31:0] addr, input logic [31:0] h);
      chk({tag, " valid"}, 32'(inst_valid), v);
      if (v[0]) begin
         chk({tag, " pc"}, inst_pc, pc);
         chk({tag, " out"}, inst_out, out);
      end
      chk({tag, " addr"}, imem_addr, addr);
      chk({tag, " halted"}, 32'(halted), h);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      ecall_en = 1'b0;
      ebreak_en = 1'b0;
      step();
      chk("rst valid", 32'(inst_valid), 32'd0);
      chk("rst halted", 32'(halted), 32'd0);
      chk("rst addr", imem_addr, 32'h0);
      chk("rst w_addr", w_addr, 32'hFFFF_FFFC);
      reset = 1'b0;
   endtask

   task automatic add(input logic [31:0] rdy, rv, rpc, ec, v, pc, out, addr, h);
      vec.push_back('{rdy, rv, rpc, ec, v, pc, out, addr, h});
   endtask

   initial begin
      //   rdy rv rpc     ec  v  pc      out     addr    h
      add(0, 0, 0,      0,  0, 0,      0,      32'h00, 0);
      add(0, 0, 0,      0,  1, 0,      0,      32'h04, 0);
      add(0, 0, 0,      0,  1, 0,      0,      32'h08, 0);
      add(0, 0, 0,      0,  1, 0,      0,      32'h08, 0);
      add(0, 0, 0,      0,  1, 0,      0,      32'h08, 0);
      add(0, 0, 0,      0,  1, 0,      0,      32'h08, 0);
      add(1, 0, 0,      0,  1, 32'h04, 32'h01, 32'h0C, 0);
      add(1, 0, 0,      0,  1, 32'h08, 32'h02, 32'h10, 0);
      add(1, 0, 0,      0,  1, 32'h0C, 32'h03, 32'h14, 0);
      add(1, 1, 32'h42, 0,  0, 0,      0,      32'h40, 0);
      add(1, 0, 0,      0,  1, 32'h40, 32'h10, 32'h44, 0);
      add(1, 0, 0,      0,  1, 32'h44, 32'h11, 32'h48, 0);
      add(1, 1, 0,      1,  0, 0,      0,      32'h00, 0);
      add(1, 0, 0,      1,  1, 32'h00, 32'h00, 32'h04, 0);
      add(1, 0, 0,      1,  1, 32'h04, 32'h01, 32'h08, 0);
      add(1, 0, 0,      1,  1, 32'h08, 32'h02, 32'h0C, 0);
      add(1, 0, 0,      1,  1, 32'h0C, 32'h73, 32'h10, 1);
      add(1, 0, 0,      1,  0, 0,      0,      32'h10, 1);
      add(1, 0, 0,      1,  0, 0,      0,      32'h10, 1);
      add(1, 1, 0,      1,  0, 0,      0,      32'h00, 0);
      add(1, 0, 0,      1,  1, 32'h00, 32'h00, 32'h04, 0);

      #2;
      do_reset();
      foreach (vec[i]) begin
         inst_ready = vec[i].rdy[0];
         redirect_valid = vec[i].rv[0];
         redirect_pc = vec[i].rpc;
         ecall_en = vec[i].ec[0];
         step();
         chk_head($sformatf("row%0d", i), vec[i].v, vec[i].pc, vec[i].out, vec[i].addr, vec[i].h);
      end

      // Redirect during BOOT, then EBREAK halts
      do_reset();
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h21;
      step();
      chk_head("boot_redir", 0, 0, 0, 32'h20, 0);
      redirect_valid = 1'b0;
      ebreak_en = 1'b1;
      step();
      chk_head("boot_first", 1, 32'h20, 32'h08, 32'h24, 0);
      step();
      chk_head("ebreak", 1, 32'h24, 32'h0010_0073, 32'h28, 1);
      step();
      chk_head("ebreak_drain", 0, 0, 0, 32'h28, 1);

      // PC wrap from RESET_PC=0xFFFFFFFC
      do_reset();
      inst_ready = 1'b1;
      step();
      chk("wrap boot valid", 32'(w_valid), 32'd0);
      step();
      chk("wrap valid0", 32'(w_valid), 32'd1);
      chk("wrap pc0", w_pc, 32'hFFFF_FFFC);
      chk("wrap out0", w_out, 32'h3FFF_FFFF);
      step();
      chk("wrap pc1", w_pc, 32'h0);
      chk("wrap out1", w_out, 32'h0);
      chk("wrap halted", 32'(w_halted), 32'd0);

      // Asynchronous reset mid-stream
      step();
      chk("pre_rst valid", 32'(inst_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async valid", 32'(inst_valid), 32'd0);
      chk("async addr", imem_addr, 32'h0);
      chk("async halted", 32'(halted), 32'd0);
      step();
      reset = 1'b0;
      step();
      chk_head("post_rst boot", 0, 0, 0, 32'h00, 0);
      step();
      chk_head("post_rst first", 1, 32'h00, 32'h00, 32'h04, 0);
      step();
      chk_head("post_rst second", 1, 32'h04, 32'h01, 32'h08, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter XLEN, default from the shared RISCV header (32): address/PC width.
REQ-002 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 Parameter DEPTH, default 2: instruction buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_addr  output  XLEN  byte address presented to instruction memory (combinational-read memory).
REQ-007 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-009 redirect_pc  input  XLEN  redirect target.
REQ-010 inst_valid  output  1  buffer head holds a valid instruction.
REQ-011 inst_ready  input  1  decode accepts head this cycle.
REQ-012 inst_out  output  32  head instruction word.
REQ-013 inst_pc  output  XLEN  PC of head instruction.
REQ-014 halted  output  1  fetcher in HALT state.

Function
REQ-015 States: BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016 imem_addr shall equal fetch_pc at all times (combinational from register).
REQ-017 Push: in RUN, no redirect, and (count<DEPTH or pop this cycle) -> write {fetch_pc, imem_data} at tail, fetch_pc <= fetch_pc+4.
REQ-018 Pop: inst_valid && inst_ready -> head advances; inst_valid = (count!=0).
REQ-019 Simultaneous push and pop when full: both occur, count unchanged, no stall bubble.
REQ-020 Full (count==DEPTH) with no pop: no push, fetch_pc holds.
REQ-021 Empty: inst_valid=0; inst_out/inst_pc don't-care but stable (no X propagation required).
REQ-022 Redirect (any state except BOOT): flush buffer (count=0) next cycle, fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, state <= RUN, no push, pop ignored that cycle.
REQ-023 Redirect during BOOT: target latched, takes effect; state goes to RUN.
REQ-024 Pushed word == 32'h00000073 (ECALL) or 32'h00100073 (EBREAK): word is pushed, then state <= HALT; HALT performs no pushes, buffer still drains.
REQ-025 HALT exits only via redirect or reset; halted=1 exactly while in HALT.
REQ-026 fetch_pc increment wraps modulo 2^XLEN (0xFFFFFFFC+4 -> 0x00000000).
REQ-027 Latency: instruction at address A visible on inst_out the cycle after fetch_pc==A with buffer empty.
REQ-028 Buffer pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.

Reset
REQ-029 On reset assertion, asynchronously: state=BOOT, fetch_pc=RESET_PC, count=0, head=tail=0, inst_valid=0, halted=0.
REQ-030 Reset mid-operation discards buffered instructions; no pop is reported after reset.
REQ-031 Buffer data storage is not reset.

Structure
REQ-032 State encodings, ECALL/EBREAK encodings, and the 4-byte instruction stride shall live in the shared RISCV header with XLEN.
REQ-033 Buffer shall be one sub-module, inst_fifo (parameters DEPTH, width 32+XLEN; push, pop, flush, full, empty, count).
REQ-034 FSM and PC logic reside in instruction_fetch; no other sub-modules.

Verification
REQ-035 Reset, RESET_PC=0, memory word i = i, inst_ready=1 -> BOOT one cycle, then inst_pc 0,4,8,... with inst_out 0,1,2,... one per cycle, no gaps.
REQ-036 inst_ready=0 for 5 cycles -> exactly DEPTH pushes, fetch_pc stops at 0x08, inst_out holds word 0; release -> sequence resumes without loss or duplication.
REQ-037 Redirect to 0x00000042 while buffer full -> next cycle inst_valid=0, following cycle inst_pc=0x40; old entries never appear.
REQ-038 ECALL at 0x0C -> 0x0C delivered, halted=1, no fetch beyond 0x10; redirect to 0x00 -> halted=0, fetch restarts at 0x00.
REQ-039 RESET_PC=0xFFFFFFFC -> inst_pc 0xFFFFFFFC then 0x00000000.
REQ-040 Assert reset mid-stream with inst_valid=1 -> inst_valid=0 immediately (asynchronously); after release sequence restarts at RESET_PC.
